// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: drives the fetch PC to a combinational instruction
// memory and buffers {PC, instruction} pairs in an in-order queue for decode.
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Enable,
  input  logic                      Redirect,
  input  logic [31:0]               RedirectTarget,
  output logic [31:0]               IM_Address,
  input  logic [31:0]               IM_Instruction,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic [31:0]               Out_Instruction,
  output logic [31:0]               Out_PC,
  output logic [31:0]               Out_PCPlus4,
  output logic [$clog2(DEPTH):0]    QueueCount
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q [DEPTH];
  entry_t        head;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic [31:0]   fetch_pc;
  logic          pop, push, full;

  assign full      = (count == FULL_CNT);
  assign Out_Valid = (count != '0);
  assign pop       = Out_Valid && Out_Ready;
  // A pop in the same cycle frees the head slot, so a full queue still streams.
  assign push      = Enable && !Redirect && (!full || pop);

  assign IM_Address = fetch_pc;
  assign QueueCount = count;

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head            = q[rptr];
  assign Out_PC          = Out_Valid ? head.pc          : 32'h0;
  assign Out_Instruction = Out_Valid ? head.instr       : 32'h0;
  assign Out_PCPlus4     = Out_Valid ? head.pc + 32'd4  : 32'h0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_pc <= RESET_PC;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else if (Redirect) begin
      fetch_pc <= {RedirectTarget[31:2], 2'b00};
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wptr     <= wptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by Out_Valid.
  always_ff @(posedge Clk) begin
    if (push) q[wptr] <= '{pc: fetch_pc, instr: IM_Instruction};
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instruction_fetch_controller;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Enable = 1'b0, Redirect = 1'b0, Out_Ready = 1'b0;
  logic [31:0] RedirectTarget = 32'h0;
  logic [31:0] IM_Address, IM_Instruction, Out_Instruction, Out_PC, Out_PCPlus4;
  logic        Out_Valid;
  logic [1:0]  QueueCount;
  logic [31:0] mxor = 32'h0;

  logic [31:0] u2_addr, u2_instr, u2_oi, u2_pc, u2_pcp4;
  logic        u2_valid;
  logic [1:0]  u2_cnt;

  always #5 Clk = ~Clk;

  assign IM_Instruction = IM_Address ^ mxor;
  assign u2_instr       = u2_addr;

  instruction_fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .IM_Address(IM_Address),
    .IM_Instruction(IM_Instruction), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Instruction(Out_Instruction), .Out_PC(Out_PC), .Out_PCPlus4(Out_PCPlus4),
    .QueueCount(QueueCount));

  instruction_fetch_controller #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .Enable(1'b1), .Redirect(1'b0),
    .RedirectTarget(32'h0), .IM_Address(u2_addr),
    .IM_Instruction(u2_instr), .Out_Valid(u2_valid), .Out_Ready(1'b1),
    .Out_Instruction(u2_oi), .Out_PC(u2_pc), .Out_PCPlus4(u2_pcp4),
    .QueueCount(u2_cnt));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetched pairs and a fetch PC.
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc = RESET_PC;
  logic [31:0] dlog[$];

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mq.delete();
      mpc <= RESET_PC;
    end else begin
      if (mq.size() > 0 && Out_Ready) void'(mq.pop_front());
      if (Redirect) begin
        mq.delete();
        mpc <= {RedirectTarget[31:2], 2'b00};
      end else if (Enable && mq.size() < DEPTH) begin
        mq.push_back('{pc: mpc, ins: mpc ^ mxor});
        mpc <= mpc + 32'd4;
      end
    end
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      chk("valid", {31'h0, Out_Valid}, {31'h0, mq.size() > 0});
      chk("count", {30'h0, QueueCount}, 32'(mq.size()));
      chk("im_addr", IM_Address, mpc);
      if (mq.size() > 0) begin
        chk("out_pc", Out_PC, mq[0].pc);
        chk("out_instr", Out_Instruction, mq[0].ins);
        chk("out_pcp4", Out_PCPlus4, mq[0].pc + 32'd4);
      end
      if (Out_Valid && Out_Ready) dlog.push_back(Out_PC);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic chk_log(input int i, input logic [31:0] exp);
    logic [31:0] v;
    v = 'x;
    if (i < dlog.size()) v = dlog[i];
    chk($sformatf("delivered[%0d]", i), v, exp);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_valid", {31'h0, Out_Valid}, 32'h0);
    chk("rst_count", {30'h0, QueueCount}, 32'h0);
    chk("rst_addr", IM_Address, RESET_PC);
    chk("rst_pc", Out_PC, 32'h0);
    chk("rst_instr", Out_Instruction, 32'h0);
    chk("rst_pcp4", Out_PCPlus4, 32'h0);
    chk("rst_addr2", u2_addr, 32'hFFFF_FFF8);

    // Free run, memory word i = i*4
    Rst = 1'b0; Enable = 1'b1; Out_Ready = 1'b1;
    dlog.delete();
    tick();
    chk("first_valid", {31'h0, Out_Valid}, 32'h1);
    chk("first_pc", Out_PC, 32'h0);
    chk("first_pcp4", Out_PCPlus4, 32'h4);
    chk("wrap_pc0", u2_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", u2_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", u2_pcp4, 32'h0);
    tick();
    chk("wrap_pc2", u2_pc, 32'h0);
    tick(4);
    for (int i = 0; i < 6; i++) chk_log(i, 32'(i * 4));

    // Stalled decode from reset
    Rst = 1'b1; mxor = 32'hA5A5_0000; Out_Ready = 1'b0;
    tick();
    Rst = 1'b0;
    dlog.delete();
    tick(5);
    chk("stall_count", {30'h0, QueueCount}, 32'h2);
    chk("stall_addr", IM_Address, 32'h8);
    chk("stall_pc", Out_PC, 32'h0);
    Out_Ready = 1'b1;
    tick(3);
    chk_log(0, 32'h0); chk_log(1, 32'h4); chk_log(2, 32'h8);
    chk("q_head12", Out_PC, 32'hC);

    // Redirect while holding 12 and 16
    Out_Ready = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h26;
    tick();
    Redirect = 1'b0;
    chk("redir_valid", {31'h0, Out_Valid}, 32'h0);
    chk("redir_addr", IM_Address, 32'h24);
    Out_Ready = 1'b1;
    tick();
    chk("redir_pc", Out_PC, 32'h24);
    chk("redir_instr", Out_Instruction, 32'hA5A5_0024);
    tick();
    chk_log(3, 32'h24);

    // Redirect concurrent with a pop of head PC 20
    Out_Ready = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h14;
    tick();
    Redirect = 1'b0;
    tick(2);
    dlog.delete();
    Out_Ready = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h40;
    tick();
    Redirect = 1'b0;
    chk("rp_count", {30'h0, QueueCount}, 32'h0);
    chk("rp_addr", IM_Address, 32'h40);
    tick(2);
    chk_log(0, 32'h14);
    chk_log(1, 32'h40);

    // Back-to-back redirects
    Redirect = 1'b1; RedirectTarget = 32'h100;
    tick();
    RedirectTarget = 32'h203;
    tick();
    Redirect = 1'b0;
    tick();
    chk("b2b_pc", Out_PC, 32'h200);
    chk("b2b_addr", IM_Address, 32'h204);

    // Enable low drains the queue and freezes the PC
    begin
      logic [31:0] a;
      Out_Ready = 1'b0;
      tick(3);
      chk("fill_count", {30'h0, QueueCount}, 32'h2);
      a = IM_Address;
      Enable = 1'b0; Out_Ready = 1'b1;
      tick(3);
      chk("drain_count", {30'h0, QueueCount}, 32'h0);
      chk("frozen_addr", IM_Address, a);
      dlog.delete();
      Enable = 1'b1;
      tick(2);
      chk_log(0, a);
    end

    // Asynchronous reset between edges with a full queue
    Out_Ready = 1'b0;
    tick(3);
    chk("pre_rst_count", {30'h0, QueueCount}, 32'h2);
    #1 Rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, Out_Valid}, 32'h0);
    chk("arst_addr", IM_Address, RESET_PC);
    chk("arst_count", {30'h0, QueueCount}, 32'h0);
    chk("arst_pc", Out_PC, 32'h0);
    chk("arst_addr2", u2_addr, 32'hFFFF_FFF8);
    tick();
    Rst = 1'b0; Out_Ready = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
